// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the async FIFO read-side drain engine.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FLUSH = 2'd2
   } rd_state_e;

   localparam int unsigned BURST_CNT_W = 16;

endpackage

// File: rtl/fifo_burst_reader.sv
// Drains an FWFT FIFO in fixed-length bursts into a registered valid/ready stream,
// flushing any stalled residue as single-beat transfers after an idle timeout.
//
// state | meaning
// IDLE  | waiting for a full burst; times out on a lingering residue
// BURST | popping BURST_LEN words, m_last on the final one
// FLUSH | popping residue words one beat at a time, each with m_last
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DW        = 8,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned CW        = 8,
   parameter int unsigned TIMEOUT   = 64,
   parameter int unsigned TW        = 8
) (
   input  logic                   clk_rd,
   input  logic                   rst,
   input  logic [DW-1:0]          fifo_dout,
   input  logic                   fifo_empty,
   input  logic                   fifo_progempty,
   output logic                   fifo_rd_en,
   output logic [DW-1:0]          m_data,
   output logic                   m_valid,
   output logic                   m_last,
   input  logic                   m_ready,
   output logic                   busy,
   output logic                   burst_done,
   output logic [BURST_CNT_W-1:0] burst_cnt
);

   rd_state_e              state_q, state_d;
   logic [CW-1:0]          beat_cnt_q, beat_cnt_d;
   logic [TW-1:0]          idle_cnt_q, idle_cnt_d;
   logic [DW-1:0]          m_data_q, m_data_d;
   logic                   m_valid_q, m_valid_d;
   logic                   m_last_q, m_last_d;
   logic                   burst_done_q, burst_done_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic                   pop;

   // The output register can take a new word when empty or being drained this cycle.
   always_comb begin
      pop = ((state_q == BURST) || (state_q == FLUSH)) && !fifo_empty
            && (!m_valid_q || m_ready);
   end

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      idle_cnt_d   = '0;
      m_data_d     = m_data_q;
      m_valid_d    = m_valid_q;
      m_last_d     = m_last_q;
      burst_done_d = 1'b0;
      burst_cnt_d  = burst_cnt_q;

      if (pop) begin
         m_data_d  = fifo_dout;
         m_valid_d = 1'b1;
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (!fifo_progempty) begin
               state_d    = BURST;
               beat_cnt_d = '0;
            end else if (!fifo_empty) begin
               if (idle_cnt_q == TW'(TIMEOUT - 1)) begin
                  state_d = FLUSH;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         BURST: begin
            if (pop) begin
               if (beat_cnt_q == CW'(BURST_LEN - 1)) begin
                  m_last_d     = 1'b1;
                  burst_done_d = 1'b1;
                  burst_cnt_d  = burst_cnt_q + 1'b1;
                  beat_cnt_d   = '0;
                  state_d      = IDLE;
               end else begin
                  m_last_d   = 1'b0;
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         FLUSH: begin
            if (pop) begin
               m_last_d = 1'b1;
            end
            if (fifo_empty || !fifo_progempty) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_rd or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         idle_cnt_q   <= '0;
         m_data_q     <= '0;
         m_valid_q    <= 1'b0;
         m_last_q     <= 1'b0;
         burst_done_q <= 1'b0;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         m_data_q     <= m_data_d;
         m_valid_q    <= m_valid_d;
         m_last_q     <= m_last_d;
         burst_done_q <= burst_done_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   assign fifo_rd_en = pop;
   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign m_last     = m_last_q;
   assign busy       = (state_q != IDLE);
   assign burst_done = burst_done_q;
   assign burst_cnt  = burst_cnt_q;

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain engine for the async FIFO's FWFT read port, running in the clk_rd domain. It waits until the FIFO holds at least one full burst, then pops exactly BURST_LEN words into a registered valid/ready output stream with a last marker on the final beat. A stalled partial residue is flushed as single-beat transfers after an idle timeout, so data never sits in the FIFO indefinitely.

## Interface
- DW, 8, data width; must equal the FIFO's DW.
- BURST_LEN, 16, beats per full burst; 2..2^CW.
- CW, 8, beat-counter width.
- TIMEOUT, 64, idle cycles with residue present before a flush starts; ≥1.
- TW, 8, timer width; 2^TW > TIMEOUT.
- clk_rd  in  1  read-domain clock.
- rst  in  1  reset: asynchronous, active-high.
- fifo_dout  in  DW  FWFT head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag (registered, rd_en-aware).
- fifo_progempty  in  1  low ⇒ FIFO holds ≥ BURST_LEN words. The FIFO is instantiated with EMPTY_HOLD = BURST_LEN-1.
- fifo_rd_en  out  1  pop strobe to the FIFO.
- m_data  out  DW  output beat data.
- m_valid  out  1  output beat valid.
- m_last  out  1  final beat of a burst; always 1 for flush beats.
- m_ready  in  1  downstream accept.
- busy  out  1  state ≠ IDLE.
- burst_done  out  1  one-cycle pulse when the last beat of a full burst is popped.
- burst_cnt  out  16  completed full bursts; wraps at 2^16.

## Operation
- FSM states: IDLE, BURST, FLUSH.
- Pop condition: fifo_rd_en = (state∈{BURST,FLUSH}) & ~fifo_empty & (~m_valid | m_ready).
  - On a pop, m_data ← fifo_dout and m_valid ← 1.
  - If m_valid & m_ready and there is no pop, m_valid ← 0.
- IDLE:
  - If fifo_progempty=0, go to BURST with beat_cnt←0. This has priority over the timer.
  - Else if fifo_empty=0, idle_cnt increments. When idle_cnt reaches TIMEOUT-1, go to FLUSH and clear idle_cnt.
  - Else idle_cnt←0.
- BURST:
  - Each pop increments beat_cnt.
  - The pop with beat_cnt=BURST_LEN-1 sets m_last←1, pulses burst_done, increments burst_cnt, and returns to IDLE.
  - Other pops set m_last←0.
  - If fifo_empty rises mid-burst, popping stalls and state holds. This is defensive only; it cannot occur when the FIFO is configured correctly.
- FLUSH:
  - Each pop sets m_last←1.
  - Returns to IDLE when fifo_empty=1 or fifo_progempty=0 (a full burst has accumulated).
  - Leaves FLUSH only between pops, never with a beat half-taken.
- m_data, m_last and m_valid hold stable while m_valid=1 and m_ready=0.
- Arithmetic: beat_cnt and idle_cnt saturate/clear as above and never wrap. burst_cnt wraps modulo 2^16.

## Timing
- Reset values:
  - state=IDLE.
  - m_valid=0, m_last=0, m_data=0.
  - fifo_rd_en=0 (combinational, forced low because state=IDLE).
  - busy=0, burst_done=0, burst_cnt=0.
  - beat_cnt=0, idle_cnt=0.
- Latency:
  - fifo_progempty falling → first fifo_rd_en 1 cycle later (IDLE→BURST register).
  - Pop → m_valid high the next cycle.
- With m_ready held at 1, a full burst is BURST_LEN consecutive pops and BURST_LEN consecutive output beats, with no bubbles.
- fifo_rd_en is combinational from m_ready. Every other output is registered.
- Back-to-back bursts: IDLE costs 1 cycle between bursts.
- Reset mid-burst: the output register is discarded, and words already popped are lost. This is accepted behaviour.

## Structure
- Shared package fifo_rd_pkg holds the state encoding constants (IDLE=2'd0, BURST=2'd1, FLUSH=2'd2) and the burst_cnt width constant (16).
- Single module, no sub-modules. The output register is inline. The FIFO itself is instantiated by the parent.

## Test plan
- **Full burst:** BURST_LEN=4; write 0x10..0x13; m_ready=1 → 4 beats 0x10..0x13, m_last only on 0x13, burst_done one pulse, burst_cnt=1.
- **Backpressure:** during a burst, m_ready=0 for 5 cycles → m_data/m_last held, fifo_rd_en=0 throughout; resumes with no loss or duplication.
- **Timeout flush:** TIMEOUT=8; write 3 words (below BURST_LEN=4) → FLUSH entered 8 cycles after fifo_empty falls; 3 beats, each with m_last=1; burst_cnt unchanged; returns to IDLE.
- **Flush preempted:** during FLUSH, the FIFO reaches 4 words → FLUSH exits to IDLE, then BURST next cycle; the following beats have m_last only on the 4th.
- **Back-to-back:** write 8 words at once → two bursts separated by exactly one IDLE cycle; burst_cnt=2.
- **Reset mid-burst:** assert rst after 2 beats → all outputs at reset values immediately; after release, state=IDLE and busy=0.
